// File: rtl/pu_noc.sv
// pu_noc: NP-channel packet interconnect between processing units.
// Every source has an ingress FIFO. Every destination round-robins
// among the sources whose FIFO head is addressed to it, and drives a
// registered pulse that lasts one cycle per delivered packet.
module pu_noc #(
  parameter int NP    = 4,
  parameter int PKTW  = 31,
  parameter int DSTW  = 2,
  parameter int DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NP*(PKTW+1)-1:0]  src_pkt,
  output logic [NP*(PKTW+1)-1:0]  dst_pkt,
  output logic [NP-1:0]           drop,
  output logic                    busy
);

  localparam int W  = PKTW + 1;
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int RW = $clog2(NP);
  localparam int CW = AW + 1;
  localparam logic [31:0]   NP_U = 32'(NP);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  // Ingress FIFO state, one set per source
  logic [W-1:0]  r_mem [NP][DEPTH];
  logic [AW-1:0] r_wr  [NP];
  logic [AW-1:0] r_rd  [NP];
  logic [CW-1:0] r_cnt [NP];
  logic          r_drop [NP];

  // Egress state, one set per destination
  logic [RW-1:0] r_rr  [NP];
  logic [W-1:0]  r_dst [NP];

  logic [W-1:0]  w_head     [NP];
  logic [NP-1:0] w_nonempty;
  logic [NP-1:0] w_push;
  logic [NP-1:0] w_pop;
  logic [NP-1:0] w_bad;
  logic [NP-1:0] w_cand     [NP];   // w_cand[d][s]: head of source s targets d
  logic [NP-1:0] w_gnt_vld;
  logic [RW-1:0] w_gnt_idx  [NP];

  for (genvar s = 0; s < NP; s++) begin : g_src
    logic [W-1:0]    w_in;
    logic [DSTW-1:0] w_in_dst;
    logic            w_full;
    logic            w_dst_ok;

    assign w_in          = src_pkt[s*W +: W];
    assign w_in_dst      = w_in[PKTW-1 -: DSTW];
    assign w_dst_ok      = 32'(w_in_dst) < NP_U;
    assign w_head[s]     = r_mem[s][r_rd[s]];
    assign w_nonempty[s] = (r_cnt[s] != '0);
    assign w_full        = (r_cnt[s] == FULL);
    // A full FIFO still accepts when its head leaves on the same edge.
    assign w_push[s]     = w_in[PKTW] && w_dst_ok && (!w_full || w_pop[s]);
    assign w_bad[s]      = w_in[PKTW] && (!w_dst_ok || (w_full && !w_pop[s]));
    assign drop[s]       = r_drop[s];

    // FIFO payload storage; contents are qualified by the count, so no reset
    always_ff @(posedge clk) begin
      if (w_push[s]) r_mem[s][r_wr[s]] <= w_in;
    end

    // FIFO pointers, occupancy and sticky drop flag
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        r_wr[s]   <= '0;
        r_rd[s]   <= '0;
        r_cnt[s]  <= '0;
        r_drop[s] <= 1'b0;
      end else begin
        if (w_push[s]) r_wr[s] <= r_wr[s] + AW'(1);
        if (w_pop[s])  r_rd[s] <= r_rd[s] + AW'(1);
        case ({w_push[s], w_pop[s]})
          2'b10:   r_cnt[s] <= r_cnt[s] + CW'(1);
          2'b01:   r_cnt[s] <= r_cnt[s] - CW'(1);
          default: r_cnt[s] <= r_cnt[s];
        endcase
        if (w_bad[s]) r_drop[s] <= 1'b1;
      end
    end
  end

  for (genvar d = 0; d < NP; d++) begin : g_cand
    for (genvar s = 0; s < NP; s++) begin : g_cs
      assign w_cand[d][s] = w_nonempty[s] &&
                            (w_head[s][PKTW-1 -: DSTW] == DSTW'(d));
    end
  end

  // Round-robin grant per destination: first candidate at or after rr[d]
  always_comb begin
    int            j;
    logic [RW-1:0] jx;
    j  = 0;
    jx = '0;
    for (int d = 0; d < NP; d++) begin
      w_gnt_vld[d] = 1'b0;
      w_gnt_idx[d] = '0;
      // Scan from farthest to nearest so the nearest candidate wins last.
      for (int k = NP - 1; k >= 0; k--) begin
        j = int'(r_rr[d]) + k;
        if (j >= NP) j = j - NP;
        jx = RW'(j);
        if (w_cand[d][jx]) begin
          w_gnt_vld[d] = 1'b1;
          w_gnt_idx[d] = jx;
        end
      end
    end
  end

  // Pop every source granted by some destination (at most one each)
  always_comb begin
    w_pop = '0;
    for (int d = 0; d < NP; d++) begin
      if (w_gnt_vld[d]) w_pop[w_gnt_idx[d]] = 1'b1;
    end
  end

  for (genvar d = 0; d < NP; d++) begin : g_dst
    // Registered delivery pulse and round-robin pointer advance
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        r_dst[d] <= '0;
        r_rr[d]  <= '0;
      end else if (w_gnt_vld[d]) begin
        r_dst[d] <= w_head[w_gnt_idx[d]];
        r_rr[d]  <= (w_gnt_idx[d] == RW'(NP - 1)) ? '0 : w_gnt_idx[d] + RW'(1);
      end else begin
        r_dst[d] <= '0;
      end
    end
    assign dst_pkt[d*W +: W] = r_dst[d];
  end

  // Activity indicator: anything queued or being delivered
  always_comb begin
    busy = 1'b0;
    for (int s = 0; s < NP; s++) begin
      if (w_nonempty[s] || r_dst[s][PKTW]) busy = 1'b1;
    end
  end

endmodule

// File: tb/tb_pu_noc.sv
// Bench for pu_noc: a 4-channel instance driven through reset, single,
// contention, overflow and full-FIFO scenarios, plus a 3-channel instance
// for out-of-range destinations and mid-burst asynchronous reset.
module tb_pu_noc;
  localparam int NP = 4;
  localparam int W  = 32;

  logic              clk = 1'b0;
  logic              rst;
  logic [NP*W-1:0]   src_pkt;
  logic [NP*W-1:0]   dst_pkt;
  logic [NP-1:0]     drop;
  logic              busy;

  logic              rst3;
  logic [3*W-1:0]    src3;
  logic [3*W-1:0]    dst3;
  logic [2:0]        drop3;
  logic              busy3;

  int n_err = 0;
  int n_chk = 0;
  int mon_mode = 0;          // 0 off, 1 keyed by destination, 2 keyed by source
  logic [31:0] q_sb [NP][$];

  pu_noc #(.NP(4), .PKTW(31), .DSTW(2), .DEPTH(4)) u_dut (
    .clk(clk), .rst(rst), .src_pkt(src_pkt), .dst_pkt(dst_pkt),
    .drop(drop), .busy(busy));

  pu_noc #(.NP(3), .PKTW(31), .DSTW(2), .DEPTH(4)) u_dut3 (
    .clk(clk), .rst(rst3), .src_pkt(src3), .dst_pkt(dst3),
    .drop(drop3), .busy(busy3));

  always #5 clk = ~clk;

  // Packet: valid, dest, zero pad, source id in [15:8], sequence in [7:0]
  function automatic logic [31:0] mk(input int d, input int s, input int q);
    return {1'b1, d[1:0], 13'h0, s[7:0], q[7:0]};
  endfunction

  // Scoreboard: every valid delivery must match the next expected packet
  always @(negedge clk) begin
    logic [31:0] got;
    logic [31:0] exp;
    int key;
    if (mon_mode != 0) begin
      for (int d = 0; d < NP; d++) begin
        got = dst_pkt[d*W +: W];
        if (got[31]) begin
          key = (mon_mode == 1) ? d : int'(got[15:8]);
          n_chk++;
          if (key >= NP) begin
            n_err++;
            $display("FAIL sb_key d=%0d: got %h, no such source", d, got);
          end else if (q_sb[key].size() == 0) begin
            n_err++;
            $display("FAIL sb_unexpected d=%0d: got %h, expected nothing", d, got);
          end else begin
            exp = q_sb[key].pop_front();
            if (got !== exp) begin
              n_err++;
              $display("FAIL sb_data d=%0d: got %h expected %h", d, got, exp);
            end
          end
        end
      end
    end
  end

  task automatic do_reset;
    @(negedge clk);
    rst = 1'b0;
    src_pkt = '0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_reset;
    rst = 1'b0;
    rst3 = 1'b0;
    src_pkt = '0;
    src3 = '0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      n_chk++;
      if (dst_pkt !== '0 || drop !== '0 || busy !== 1'b0) begin
        n_err++;
        $display("FAIL reset_hold: dst=%h drop=%b busy=%b, required all 0", dst_pkt, drop, busy);
      end
      src_pkt = {$urandom, $urandom, $urandom, $urandom};
    end
    @(negedge clk);
    src_pkt = '0;
    rst = 1'b1;
    rst3 = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      n_chk++;
      if (dst_pkt !== '0 || drop !== '0 || busy !== 1'b0) begin
        n_err++;
        $display("FAIL reset_release: dst=%h drop=%b busy=%b, required all 0", dst_pkt, drop, busy);
      end
    end
  endtask

  task automatic test_single;
    logic [31:0]   pkt;
    logic [NP*W-1:0] exp;
    mon_mode = 1;
    pkt = {1'b1, 2'd2, 29'h12345};
    exp = '0;
    exp[2*W +: W] = pkt;
    @(negedge clk);
    src_pkt[1*W +: W] = pkt;
    q_sb[2].push_back(pkt);
    @(negedge clk);
    src_pkt = '0;
    n_chk++;
    if (dst_pkt !== '0 || busy !== 1'b1) begin
      n_err++;
      $display("FAIL single_edge0: dst=%h busy=%b, required dst=0 busy=1", dst_pkt, busy);
    end
    @(negedge clk);
    n_chk++;
    if (dst_pkt !== exp) begin
      n_err++;
      $display("FAIL single_edge1: dst=%h, required %h", dst_pkt, exp);
    end
    @(negedge clk);
    n_chk++;
    if (dst_pkt !== '0 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL single_edge2: dst=%h busy=%b, required dst=0 busy=0", dst_pkt, busy);
    end
  endtask

  task automatic test_contention;
    int order [3];
    order = '{0, 1, 3};
    do_reset();
    mon_mode = 1;
    for (int rep = 0; rep < 2; rep++) begin
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
        src_pkt[order[i]*W +: W] = mk(2, order[i], rep);
        q_sb[2].push_back(mk(2, order[i], rep));
      end
      @(negedge clk);
      src_pkt = '0;
      n_chk++;
      if (dst_pkt[2*W+31] !== 1'b0) begin
        n_err++;
        $display("FAIL cont_early rep=%0d: valid=%b, required 0", rep, dst_pkt[2*W+31]);
      end
      for (int c = 0; c < 3; c++) begin
        @(negedge clk);
        n_chk++;
        if (dst_pkt[2*W +: W] !== mk(2, order[c], rep)) begin
          n_err++;
          $display("FAIL cont_slot rep=%0d c=%0d: got %h, required %h",
                   rep, c, dst_pkt[2*W +: W], mk(2, order[c], rep));
        end
      end
      @(negedge clk);
      n_chk++;
      if (dst_pkt !== '0 || busy !== 1'b0) begin
        n_err++;
        $display("FAIL cont_drain rep=%0d: dst=%h busy=%b, required 0", rep, dst_pkt, busy);
      end
    end
  endtask

  task automatic test_overflow;
    // Accepted sequence numbers per source, worked out by hand from the
    // round-robin pop schedule on destination 0.
    logic [7:0] acc [NP];
    int n_del, first, last;
    acc = '{8'h3F, 8'h5F, 8'h9F, 8'h1F};
    do_reset();
    mon_mode = 2;
    for (int s = 0; s < NP; s++)
      for (int q = 0; q < 8; q++)
        if (acc[s][q]) q_sb[s].push_back(mk(0, s, q));
    n_del = 0;
    first = -1;
    last = -1;
    for (int cyc = 0; cyc < 40; cyc++) begin
      @(negedge clk);
      if (dst_pkt[31]) begin
        n_del++;
        if (first < 0) first = cyc;
        last = cyc;
      end
      if (cyc < 8) begin
        for (int s = 0; s < NP; s++) src_pkt[s*W +: W] = mk(0, s, cyc);
      end else begin
        src_pkt = '0;
      end
    end
    n_chk++;
    if (n_del !== 23) begin
      n_err++;
      $display("FAIL ovf_count: delivered %0d, required 23", n_del);
    end
    n_chk++;
    if (first !== 2 || last !== 24) begin
      n_err++;
      $display("FAIL ovf_stream: first=%0d last=%0d, required 2 and 24", first, last);
    end
    n_chk++;
    if (drop !== 4'hF || busy !== 1'b0) begin
      n_err++;
      $display("FAIL ovf_drop: drop=%b busy=%b, required 1111 and 0", drop, busy);
    end
    for (int s = 0; s < NP; s++) begin
      n_chk++;
      if (q_sb[s].size() != 0) begin
        n_err++;
        $display("FAIL ovf_missing src=%0d: %0d packets left, required 0", s, q_sb[s].size());
        q_sb[s].delete();
      end
    end
  endtask

  task automatic test_full_pushpop;
    do_reset();
    mon_mode = 1;
    for (int s = 0; s < NP; s++) q_sb[1].push_back(mk(1, s, 0));
    for (int q = 1; q <= 5; q++) q_sb[1].push_back(mk(1, 0, q));
    for (int cyc = 0; cyc < 14; cyc++) begin
      @(negedge clk);
      if (cyc == 6) begin
        n_chk++;
        if (drop !== 4'h0) begin
          n_err++;
          $display("FAIL full_pushpop_drop: drop=%b, required 0000", drop);
        end
      end
      if (cyc == 0) begin
        for (int s = 0; s < NP; s++) src_pkt[s*W +: W] = mk(1, s, 0);
      end else if (cyc <= 5) begin
        src_pkt = '0;
        src_pkt[0 +: W] = mk(1, 0, cyc);
      end else begin
        src_pkt = '0;
      end
    end
    n_chk++;
    if (q_sb[1].size() != 0 || busy !== 1'b0 || drop !== 4'h0) begin
      n_err++;
      $display("FAIL full_pushpop_end: left=%0d busy=%b drop=%b, required 0/0/0000",
               q_sb[1].size(), busy, drop);
      q_sb[1].delete();
    end
  endtask

  task automatic test_bad_dest;
    logic [31:0] p0;
    p0 = {1'b1, 2'd1, 29'h1A1};
    @(negedge clk);
    src3[0 +: W] = {1'b1, 2'd3, 29'h55};
    @(negedge clk);
    src3 = '0;
    n_chk++;
    if (drop3 !== 3'b001 || dst3 !== '0 || busy3 !== 1'b0) begin
      n_err++;
      $display("FAIL bad_dest: drop=%b dst=%h busy=%b, required 001/0/0", drop3, dst3, busy3);
    end
    @(negedge clk);
    n_chk++;
    if (dst3 !== '0) begin
      n_err++;
      $display("FAIL bad_dest_late: dst=%h, required 0", dst3);
    end
    // Burst, then asynchronous reset between clock edges
    @(negedge clk);
    src3[0 +: W] = p0;
    src3[W +: W] = {1'b1, 2'd2, 29'h2B2};
    @(negedge clk);
    src3[0 +: W] = {1'b1, 2'd1, 29'h1A2};
    src3[W +: W] = {1'b1, 2'd2, 29'h2B3};
    @(negedge clk);
    n_chk++;
    if (dst3[W +: W] !== p0) begin
      n_err++;
      $display("FAIL burst_deliver: got %h, required %h", dst3[W +: W], p0);
    end
    #2;
    rst3 = 1'b0;
    #1;
    n_chk++;
    if (dst3 !== '0 || busy3 !== 1'b0 || drop3 !== 3'b000) begin
      n_err++;
      $display("FAIL async_reset: dst=%h busy=%b drop=%b, required 0", dst3, busy3, drop3);
    end
    @(negedge clk);
    src3 = '0;
    @(negedge clk);
    rst3 = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      n_chk++;
      if (dst3 !== '0 || busy3 !== 1'b0) begin
        n_err++;
        $display("FAIL stale_after_reset c=%0d: dst=%h busy=%b, required 0", c, dst3, busy3);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_overflow();
    test_full_pushpop();
    test_bad_dest();
    @(negedge clk);
    for (int d = 0; d < NP; d++) begin
      n_chk++;
      if (q_sb[d].size() != 0) begin
        n_err++;
        $display("FAIL sb_leftover key=%0d: %0d packets left, required 0", d, q_sb[d].size());
      end
    end
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/pu_noc.md
Name: pu_noc

Overview:
- Parametrised packet interconnect between NP processing units. Generalises the fixed point-to-point rx/tx wiring to NP channels.
- Each source channel takes a PU's tx packet into a per-source ingress FIFO. Each destination channel drives a PU's rx, using round-robin arbitration among the source FIFOs whose head packet targets that destination.
- Sits at the top level; PU tx ports connect to src_pkt and PU rx ports to dst_pkt.

Parameters:
NP, 4, number of channels (PUs), 2..16
PKTW, 31, packet MSB index; packet width is PKTW+1
DSTW, 2, destination-field width; must satisfy 2**DSTW >= NP
DEPTH, 4, ingress FIFO entries per source; power of 2, >= 2

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-low
src_pkt  in  NP*(PKTW+1)  flattened PU tx packets; channel s = bits [s*(PKTW+1) +: PKTW+1]
dst_pkt  out  NP*(PKTW+1)  flattened PU rx packets; same slicing
drop  out  NP  sticky per-source drop flag
busy  out  1  any FIFO non-empty or any dst_pkt valid

Behaviour:
- Packet format: bit PKTW = valid; bits [PKTW-1 -: DSTW] = destination id; remaining low bits = payload. The packet is forwarded unmodified.
- Reset (rst=0, asynchronous): all FIFOs empty, all round-robin pointers rr[d]=0, dst_pkt=0, drop=0, busy=0. Reset mid-operation discards all queued and in-flight packets.
- Ingress, per source s, each posedge:
  - valid=1 and dest < NP and FIFO not full -> push.
  - FIFO full and head popped the same cycle -> push accepted (simultaneous push/pop); count unchanged.
  - FIFO full and no pop -> packet discarded, drop[s] <= 1.
  - dest >= NP -> packet discarded, drop[s] <= 1.
  - valid=0 -> nothing pushed.
- FIFO: circular buffer, read/write pointers wrap at DEPTH. Head-of-line blocking is accepted.
- Arbitration, per destination d, combinational each cycle:
  - Candidates are sources with a non-empty FIFO whose head dest == d.
  - Grant the first candidate at or after rr[d], scanning cyclically.
  - At the posedge: the granted head is popped, dst_pkt[d] <= head packet, rr[d] <= (grant+1) mod NP.
  - No candidate -> dst_pkt[d] <= 0 and rr[d] is unchanged.
- A source head targets exactly one destination, so at most one pop per FIFO per cycle. Self-send (s == d) is legal.
- dst_pkt is registered and held for exactly one cycle per packet (pulse). Back-to-back deliveries to the same d on consecutive cycles are allowed.
- Latency: a packet sampled at edge t into an empty, uncontended FIFO appears on dst_pkt after edge t+1 (2-cycle latency).
- Ordering: per (source, destination) pair, delivery order equals acceptance order. No duplication and no loss except counted drops.
- drop bits clear only on reset.
- busy is combinational from FIFO counts and dst_pkt valid bits.

Test Plan:
1. Reset: hold rst=0 with random src_pkt and clk toggling -> dst_pkt=0, drop=0, busy=0 throughout. Release rst -> still 0 until a packet arrives.
2. Single packet (NP=4, PKTW=31, DSTW=2): src1 = valid, dest 2, payload 0x12345 at edge 0 -> dst_pkt[2] equals the same 32-bit word after edge 1 for exactly one cycle. Other channels are 0; busy deasserts after edge 2.
3. Contention: src0, src1 and src3 send to dest 2 at the same edge (rr[2]=0) -> delivered from src0, src1, src3 on three consecutive cycles, after which rr[2]=0. Repeat the burst -> src0 is again delivered first.
4. Overflow (DEPTH=4): sources 0-3 each send 8 back-to-back packets to dest 0 -> drop[0..3]=1. Every delivered packet is unique, per-source payloads arrive in increasing sequence, delivered + dropped = 32, and dest 0 receives one packet per cycle until drained.
5. Full-FIFO simultaneous push/pop: fill src0's FIFO to 4 entries while dest 1 is contended, then push while the src0 head is granted -> packet accepted, drop[0] stays 0.
6. Bad destination (NP=3): src0 sends dest 3 -> nothing delivered, drop[0]=1 at the next edge. Then assert rst low mid-burst without a clock edge -> dst_pkt=0 immediately, and no stale packet appears after release.
